operand_entry_sequencer: RTL and testbench

//   Upstream stage of the 4-bit add/subtract datapath on the board.

---
 rtl/operand_entry_sequencer_pkg.sv | 28 ++
 rtl/button_debouncer.sv | 77 +++++++
 rtl/operand_entry_sequencer.sv | 111 +++++++++++
 tb/tb_operand_entry_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_entry_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : operand_entry_sequencer_pkg
// Description : Stage encodings and operation codes shared by the operand
//               entry sequencer and the downstream display/decoder stage.
// Revision    : 1.0 - initial release
// ============================================================================
package operand_entry_sequencer_pkg;

  // Stage encodings as seen on the status LEDs.
  localparam logic [1:0] ST_LOAD_A  = 2'd0;
  localparam logic [1:0] ST_LOAD_B  = 2'd1;
  localparam logic [1:0] ST_LOAD_OP = 2'd2;
  localparam logic [1:0] ST_SHOW    = 2'd3;

  // Operation select, driven straight onto the adder carry-in.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    LOAD_A  = ST_LOAD_A,
    LOAD_B  = ST_LOAD_B,
    LOAD_OP = ST_LOAD_OP,
    SHOW    = ST_SHOW
  } stage_e;

endpackage : operand_entry_sequencer_pkg
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Synchronises a raw, bouncing push button, filters it with a
//               stability counter and emits a one-cycle pulse on each
//               accepted press (rising edge of the debounced level).
// Ports       : clk     - system clock
//               rst_n   - asynchronous active-low reset
//               btn_raw - raw asynchronous button input, active high
//               level   - debounced button level
//               press   - one-cycle pulse on debounced 0->1 transition
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer
  import operand_entry_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  // The level flips on the edge that completes the DEBOUNCE_CYCLES-th
  // consecutive differing sample, i.e. when the counter already holds N-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             level_prev_q, level_prev_d;

  always_comb begin
    sync1_d      = btn_raw;
    sync2_d      = sync1_q;
    cnt_d        = cnt_q;
    level_d      = level_q;
    level_prev_d = level_q;

    if (sync2_q == level_q) begin
      // Any reversion restarts the stability count.
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      // Counter is cleared on acceptance, so it never exceeds N-1.
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
    end
  end

  assign level = level_q;
  // Both terms are flops, so the pulse is glitch-free.
  assign press = level_q & ~level_prev_q;

endmodule : button_debouncer
`default_nettype wire

// File: rtl/operand_entry_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : operand_entry_sequencer
// Description : Captures operand A, operand B and the add/subtract select
//               from a shared switch bank over three debounced button
//               presses, and presents them to the adder with a valid flag.
// Ports       : clk   - system clock
//               rst_n - asynchronous active-low reset
//               sw    - switch bank, sampled only on an accepted press
//               btn   - raw push button, active high
//               a, b  - registered operands to the adder
//               cin   - registered op select / carry-in (1 = subtract)
//               valid - a, b and cin form a complete set
//               stage - current entry stage for status LEDs
// Revision    : 1.0 - initial release
// ============================================================================
module operand_entry_sequencer
  import operand_entry_sequencer_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             cin,
  output logic             valid,
  output logic [1:0]       stage
);

  logic press;
  logic unused_level;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_button_debouncer (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn),
    .level   (unused_level),
    .press   (press)
  );

  stage_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic             valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    valid_d = valid_q;

    if (press) begin
      case (state_q)
        LOAD_A: begin
          a_d     = sw;
          state_d = LOAD_B;
        end
        LOAD_B: begin
          b_d     = sw;
          state_d = LOAD_OP;
        end
        LOAD_OP: begin
          cin_d   = sw[0];
          valid_d = 1'b1;
          state_d = SHOW;
        end
        SHOW: begin
          // Operands are kept so the display keeps the last result context.
          valid_d = 1'b0;
          state_d = LOAD_A;
        end
        default: begin
          valid_d = 1'b0;
          state_d = LOAD_A;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= OP_ADD;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      valid_q <= valid_d;
    end
  end

  assign a     = a_q;
  assign b     = b_q;
  assign cin   = cin_q;
  assign valid = valid_q;
  assign stage = state_q;

endmodule : operand_entry_sequencer
`default_nettype wire

// File: tb/tb_operand_entry_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_entry_sequencer
// Description : Self-checking bench for operand_entry_sequencer with a short
//               debounce window and a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_entry_sequencer;

  localparam int WIDTH = 4;
  localparam int DC    = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] sw;
  logic             btn;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             valid;
  logic [1:0]       stage;

  int checks;
  int errors;

  operand_entry_sequencer #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw),
    .btn   (btn),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .valid (valid),
    .stage (stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: btn history per clock edge; the debounced level flips
  // when the DC samples seen after the two-cycle synchroniser all differ
  // from it. A rising flip requests one FSM step on the following edge.
  bit               hist[$];
  bit               m_level;
  bit               m_press;
  logic [WIDTH-1:0] m_a, m_b;
  logic             m_cin, m_valid;
  int               m_stage;

  task automatic model_reset();
    hist    = {};
    for (int i = 0; i < DC + 2; i++) hist.push_back(1'b0);
    m_level = 1'b0;
    m_press = 1'b0;
    m_a     = '0;
    m_b     = '0;
    m_cin   = 1'b0;
    m_valid = 1'b0;
    m_stage = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      bit all_diff;
      if (m_press) begin
        case (m_stage)
          0:       begin m_a = sw;               m_stage = 1; end
          1:       begin m_b = sw;               m_stage = 2; end
          2:       begin m_cin = sw[0]; m_valid = 1'b1; m_stage = 3; end
          default: begin m_valid = 1'b0;         m_stage = 0; end
        endcase
      end
      m_press = 1'b0;
      hist.push_back(btn);
      all_diff = 1'b1;
      for (int j = 0; j < DC; j++)
        if (hist[hist.size() - 3 - j] == m_level) all_diff = 1'b0;
      if (all_diff) begin
        m_level = ~m_level;
        m_press = m_level;
      end
      if (hist.size() > 64) void'(hist.pop_front());
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [WIDTH-1:0] v);
    @(negedge clk);
    sw  = v;
    btn = 1'b1;
    cycles(8);
    btn = 1'b0;
    cycles(10);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn   = 1'b0;
    sw    = 4'hF;
    cycles(3);
    checks++;
    if ({a, b, cin, valid, stage} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state got a=%h b=%h cin=%b valid=%b stage=%0d want all 0",
               a, b, cin, valid, stage);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({a, b, cin, valid, stage} !== 11'd0) begin
        errors++;
        $display("FAIL idle_hold cyc=%0d got a=%h b=%h cin=%b valid=%b stage=%0d want all 0",
                 i, a, b, cin, valid, stage);
      end
    end
  endtask

  task automatic test_add();
    press(4'h5);
    press(4'h3);
    @(negedge clk);
    sw  = 4'h0;
    btn = 1'b1;
    cycles(6);
    checks++;
    if (valid !== 1'b0 || stage !== 2'd2) begin
      errors++;
      $display("FAIL add_early got valid=%b stage=%0d want valid=0 stage=2", valid, stage);
    end
    cycles(1);
    checks++;
    if (a !== 4'h5 || b !== 4'h3 || cin !== 1'b0 || valid !== 1'b1 || stage !== 2'd3) begin
      errors++;
      $display("FAIL add_show got a=%h b=%h cin=%b valid=%b stage=%0d want 5 3 0 1 3",
               a, b, cin, valid, stage);
    end
    cycles(2);
    btn = 1'b0;
    cycles(10);
  endtask

  task automatic test_sub();
    press(4'h9);  // SHOW -> LOAD_A
    press(4'h5);
    press(4'h3);
    press(4'h1);
    checks++;
    if (a !== 4'h5 || b !== 4'h3 || cin !== 1'b1 || valid !== 1'b1 || stage !== 2'd3) begin
      errors++;
      $display("FAIL sub_show got a=%h b=%h cin=%b valid=%b stage=%0d want 5 3 1 1 3",
               a, b, cin, valid, stage);
    end
    press(4'hE);
    checks++;
    if (a !== 4'h5 || b !== 4'h3 || valid !== 1'b0 || stage !== 2'd0) begin
      errors++;
      $display("FAIL sub_wrap got a=%h b=%h valid=%b stage=%0d want 5 3 0 0",
               a, b, valid, stage);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      btn = ((i / 2) % 2 == 0);
      sw  = 4'($urandom);
    end
    @(negedge clk);
    btn = 1'b0;
    cycles(12);
    checks++;
    if (stage !== 2'd0 || a !== 4'h5) begin
      errors++;
      $display("FAIL bounce got stage=%0d a=%h want stage=0 a=5", stage, a);
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    sw  = 4'hA;
    btn = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i == 20) sw = 4'h6;
      if (i == 100) begin
        checks++;
        if (stage !== 2'd1 || a !== 4'hA) begin
          errors++;
          $display("FAIL hold_mid got stage=%0d a=%h want stage=1 a=a", stage, a);
        end
      end
    end
    btn = 1'b0;
    cycles(12);
    checks++;
    if (stage !== 2'd1 || a !== 4'hA) begin
      errors++;
      $display("FAIL hold_release got stage=%0d a=%h want stage=1 a=a", stage, a);
    end
  endtask

  task automatic test_reset_mid();
    press(4'h7);
    checks++;
    if (stage !== 2'd2 || b !== 4'h7) begin
      errors++;
      $display("FAIL pre_reset got stage=%0d b=%h want stage=2 b=7", stage, b);
    end
    @(negedge clk);
    btn = 1'b1;
    cycles(3);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a, b, cin, valid, stage} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset got a=%h b=%h cin=%b valid=%b stage=%0d want all 0",
               a, b, cin, valid, stage);
    end
    @(negedge clk);
    btn = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(3);
    checks++;
    if (stage !== 2'd0) begin
      errors++;
      $display("FAIL reset_no_press got stage=%0d want 0", stage);
    end
    press(4'h9);
    checks++;
    if (stage !== 2'd1 || a !== 4'h9 || b !== 4'h0) begin
      errors++;
      $display("FAIL post_reset got stage=%0d a=%h b=%h want 1 9 0", stage, a, b);
    end
  endtask

  task automatic test_random();
    int run;
    run = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      checks++;
      if (a !== m_a || b !== m_b || cin !== m_cin || valid !== m_valid ||
          stage !== 2'(m_stage)) begin
        errors++;
        $display("FAIL random cyc=%0d got a=%h b=%h cin=%b valid=%b stage=%0d want %h %h %b %b %0d",
                 i, a, b, cin, valid, stage, m_a, m_b, m_cin, m_valid, m_stage);
      end
      checks++;
      if (valid === 1'b1 && stage !== 2'd3) begin
        errors++;
        $display("FAIL valid_outside_show cyc=%0d got stage=%0d want 3", i, stage);
      end
      if (run == 0) begin
        btn = ~btn;
        run = $urandom_range(1, 10);
      end
      run--;
      sw = 4'($urandom);
    end
    btn = 1'b0;
    cycles(12);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    btn    = 1'b0;
    sw     = '0;
    rst_n  = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_bounce();
    test_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_operand_entry_sequencer
`default_nettype wire
